p_mul_seq: RTL and testbench
============================

Name: p_mul_seq

Overview:
- Multi-cycle unsigned packed multiplier that sits upstream of the packed add/sub datapath in the crypto ALU.
- Each lane computes lhs_lane * rhs_lane by shift-and-add, one step per cycle.
- Each step is a lane-masked packed add whose per-lane carry-out feeds a lane-local right shift.
- Returns the low or high half of each 2W-bit lane product.

Parameters:
- None. Lane width is selected at run time by pw.

Ports:
- g_clk  input  1  clock; all state on rising edge.
- g_resetn  input  1  asynchronous, active-low reset.
- valid  input  1  request; hold high until ready.
- flush  input  1  abort current operation, return to IDLE.
- lhs  input  32  multiplicand, packed.
- rhs  input  32  multiplier, packed.
- pw  input  5  one-hot pack width: [0]=32, [1]=16, [2]=8, [3]=4, [4]=2.
- high  input  1  1: return high halves; 0: return low halves.
- carryless  input  1  carry-less multiply select (see Optional Feature).
- ready  output  1  one-cycle pulse; result valid this cycle.
- result  output  32  packed product halves.

Behaviour:
- Reset (async, g_resetn=0):
  - state=IDLE; ready=0; result=0; acc_hi=0; acc_lo=0; lhs_r=0; count=0.
- Registers:
  - lhs_r, acc_hi, acc_lo (32 each).
  - count (6b); high_r; pw_r; cl_r.
- IDLE, valid=1, flush=0, pw one-hot:
  - Load lhs_r=lhs, acc_hi=0, acc_lo=rhs, latch pw/high/carryless.
  - count=W (lane width: 32/16/8/4/2).
  - Go to BUSY.
- IDLE, valid=1, pw not one-hot (zero or multi-hot):
  - Go directly to DONE with result=0.
- BUSY step, each lane independently:
  - If the lane LSB of acc_lo is 1: {c,s} = acc_hi_lane + lhs_r_lane, with no carry across lane boundaries; c is that lane's MSB carry-out.
  - Else: s = acc_hi_lane, c = 0.
  - Then: acc_hi_lane = {c, s[W-1:1]}; acc_lo_lane = {s[0], acc_lo_lane[W-1:1]}.
  - count decrements; when count reaches 1 this step, go to DONE.
- DONE:
  - ready=1 for exactly one cycle.
  - result = high_r ? acc_hi : acc_lo.
  - Go to IDLE.
- result holds its value until the next DONE or reset.
- Latency: accept edge, then W BUSY edges; ready high in the cycle after the W-th step (W+1 cycles after accept). The invalid-pw path takes 1 cycle.
- Requester deasserts valid in the cycle after ready. If valid is still high in IDLE, a new operation is accepted.
- flush=1 in any state:
  - Next state IDLE; ready stays 0; result unchanged.
  - flush has priority over valid and over BUSY completion.
- Changes to lhs/rhs/pw/high while BUSY are ignored; all operands are latched at accept.
- Reset mid-operation: immediate return to the reset values above; no ready pulse.
- Products are unsigned, modulo 2^(2W) per lane; no saturation.

Optional Feature:
- Macro P_MUL_SEQ_CARRYLESS_EN.
- Defined:
  - When cl_r=1, the step addition is replaced by lane-wise XOR and c is forced to 0 (GF(2)[x] multiply).
  - result high/low select applies unchanged.
- Undefined:
  - carryless is ignored (treated as 0).
  - No XOR path is synthesised.
- Latency is identical either way.

Test Plan:
- pw=5'b00001, lhs=5, rhs=7, high=0 -> ready exactly 33 cycles after accept, result=0x00000023. Same operands with high=1 -> 0x00000000.
- pw=5'b00010, lhs=0xFFFF0003, rhs=0x00020004 -> high=0: 0xFFFE000C; high=1: 0x00010000. ready 17 cycles after accept.
- pw=5'b01000, lhs=rhs=0xFFFFFFFF -> high=0: 0x11111111; high=1: 0xEEEEEEEE.
  - pw=5'b10000, same operands -> high=0: 0x55555555; high=1: 0xAAAAAAAA.
  - pw=5'b00100, lhs=0x10203040, rhs=0x02020202, high=0 -> 0x20406080.
- Abort cases:
  - flush at BUSY cycle 5 -> no ready pulse, IDLE next cycle, result holds its previous value.
  - g_resetn low mid-BUSY -> ready=0, result=0 immediately.
  - pw=5'b00011 -> ready 1 cycle after accept, result=0.
- P_MUL_SEQ_CARRYLESS_EN defined, carryless=1, pw=5'b00001, lhs=3, rhs=3 -> result 0x00000005.
  - With macro undefined, same stimulus -> 0x00000009.

Source files
------------

// File: rtl/p_mul_seq.sv
// ============================================================================
// Module      : p_mul_seq
// Description : Multi-cycle unsigned packed multiplier. Each lane (32/16/8/4/2
//               bits, selected at run time by one-hot pw) is multiplied by
//               shift-and-add, one lane-masked packed add and shift per cycle.
//               Returns the low or high half of each 2W-bit lane product.
// Options     : `define P_MUL_SEQ_CARRYLESS_EN enables the carry-less
//               (GF(2)[x]) multiply path selected by the carryless input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p_mul_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [4:0]  pw,
  input  logic        high,
  input  logic        carryless,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_lhs;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [5:0]  r_count;
  logic        r_high;
  logic [4:0]  r_pw;
  logic        r_ready;
  logic [31:0] r_result;

  logic [31:0] w_lsb_mask;
  logic [31:0] w_msb_mask;
  logic [31:0] w_sum;
  logic [31:0] w_cout;
  logic [31:0] w_sum_sr;
  logic [31:0] w_lo_sr;
  logic [31:0] w_next_hi;
  logic [31:0] w_next_lo;
  logic        w_cl;

`ifdef P_MUL_SEQ_CARRYLESS_EN
  logic        r_cl;

  // Carry-less mode flag, latched at accept.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_cl <= 1'b0;
    end else if (!flush && (r_state == S_IDLE) && valid && $onehot(pw)) begin
      r_cl <= carryless;
    end
  end

  assign w_cl = r_cl;
`else
  logic        w_unused_carryless;

  assign w_unused_carryless = carryless;
  assign w_cl               = 1'b0;
`endif

  // Lane width in bits for a one-hot pack-width code (0 if not one-hot).
  function automatic logic [5:0] f_width(input logic [4:0] p);
    case (p)
      5'b00001: f_width = 6'd32;
      5'b00010: f_width = 6'd16;
      5'b00100: f_width = 6'd8;
      5'b01000: f_width = 6'd4;
      5'b10000: f_width = 6'd2;
      default:  f_width = 6'd0;
    endcase
  endfunction

  // Bits that start a lane; the lane MSB is the bit just below each start.
  always_comb begin
    case (r_pw)
      5'b00010: w_lsb_mask = 32'h0001_0001;
      5'b00100: w_lsb_mask = 32'h0101_0101;
      5'b01000: w_lsb_mask = 32'h1111_1111;
      5'b10000: w_lsb_mask = 32'h5555_5555;
      default:  w_lsb_mask = 32'h0000_0001;
    endcase
  end

  assign w_msb_mask = {w_lsb_mask[0], w_lsb_mask[31:1]};

  // Lane-masked add of acc_hi and (lhs gated by the lane's multiplier bit);
  // the carry chain is cut at every lane start.
  always_comb begin : b_add
    logic en;
    logic cy;
    logic b;
    en     = 1'b0;
    cy     = 1'b0;
    b      = 1'b0;
    w_sum  = '0;
    w_cout = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_lsb_mask[i]) begin
        en = r_acc_lo[i];
        cy = 1'b0;
      end
      b        = r_lhs[i] & en;
      w_sum[i] = r_acc_hi[i] ^ b ^ cy;
      cy       = (r_acc_hi[i] & b) | (r_acc_hi[i] & cy) | (b & cy);
      if (w_cl) begin
        cy = 1'b0;
      end
      w_cout[i] = cy;
    end
  end

  assign w_sum_sr = {1'b0, w_sum[31:1]};
  assign w_lo_sr  = {1'b0, r_acc_lo[31:1]};

  // Lane-local right shift of {carry, sum, acc_lo}.
  always_comb begin : b_shift
    logic s0;
    s0        = 1'b0;
    w_next_hi = '0;
    w_next_lo = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_lsb_mask[i]) begin
        s0 = w_sum[i];
      end
      if (w_msb_mask[i]) begin
        w_next_hi[i] = w_cout[i];
        w_next_lo[i] = s0;
      end else begin
        w_next_hi[i] = w_sum_sr[i];
        w_next_lo[i] = w_lo_sr[i];
      end
    end
  end

  // Control FSM with registered ready/result; flush overrides everything.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_result <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_lhs    <= '0;
      r_count  <= '0;
      r_high   <= 1'b0;
      r_pw     <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (valid) begin
            if ($onehot(pw)) begin
              r_lhs    <= lhs;
              r_acc_hi <= '0;
              r_acc_lo <= rhs;
              r_pw     <= pw;
              r_high   <= high;
              r_count  <= f_width(pw);
              r_state  <= S_BUSY;
            end else begin
              r_result <= '0;
              r_ready  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_acc_hi <= w_next_hi;
          r_acc_lo <= w_next_lo;
          r_count  <= r_count - 6'd1;
          if (r_count == 6'd1) begin
            r_result <= r_high ? w_next_hi : w_next_lo;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_p_mul_seq.sv
// ============================================================================
// Module      : tb_p_mul_seq
// Description : Self-checking bench for p_mul_seq; directed cases plus random
//               operations checked against an arithmetic lane-product model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p_mul_seq;

  logic        g_clk     = 1'b0;
  logic        g_resetn  = 1'b0;
  logic        valid     = 1'b0;
  logic        flush     = 1'b0;
  logic [31:0] lhs       = '0;
  logic [31:0] rhs       = '0;
  logic [4:0]  pw        = '0;
  logic        high      = 1'b0;
  logic        carryless = 1'b0;
  logic        ready;
  logic [31:0] result;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_result = '0;

`ifdef P_MUL_SEQ_CARRYLESS_EN
  localparam bit CL_EN = 1'b1;
`else
  localparam bit CL_EN = 1'b0;
`endif

  always #5 g_clk = ~g_clk;

  p_mul_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .valid     (valid),
    .flush     (flush),
    .lhs       (lhs),
    .rhs       (rhs),
    .pw        (pw),
    .high      (high),
    .carryless (carryless),
    .ready     (ready),
    .result    (result)
  );

  function automatic int lane_w(input logic [4:0] p);
    case (p)
      5'b00001: return 32;
      5'b00010: return 16;
      5'b00100: return 8;
      5'b01000: return 4;
      5'b10000: return 2;
      default:  return 0;
    endcase
  endfunction

  // Reference: per-lane full product (integer or GF(2) polynomial), then half-select.
  function automatic logic [31:0] ref_mul(input logic [31:0] a_in, input logic [31:0] b_in,
                                          input logic [4:0] p, input logic hi, input logic cl);
    int w;
    logic [63:0] m, a, b, prod, res;
    w = lane_w(p);
    if (w == 0) return 32'h0;
    m   = (64'd1 << w) - 64'd1;
    res = '0;
    for (int l = 0; l < 32 / w; l++) begin
      a = (64'(a_in) >> (l * w)) & m;
      b = (64'(b_in) >> (l * w)) & m;
      if (cl && CL_EN) begin
        prod = '0;
        for (int k = 0; k < w; k++) if (b[k]) prod = prod ^ (a << k);
      end else begin
        prod = a * b;
      end
      if (hi) prod = prod >> w;
      res = res | ((prod & m) << (l * w));
    end
    return res[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request: hold valid until ready, scramble operands while busy.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] p, input logic hi, input logic cl,
                        input logic [31:0] exp);
    int n;
    logic seen;
    int exp_lat;
    exp_lat = (lane_w(p) == 0) ? 1 : lane_w(p) + 1;
    @(negedge g_clk);
    lhs = a; rhs = b; pw = p; high = hi; carryless = cl; valid = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge g_clk); #1;
      n++;
      if (ready) seen = 1'b1;
      else begin
        lhs = $urandom; rhs = $urandom; pw = 5'($urandom);
        high = 1'($urandom); carryless = 1'($urandom);
      end
    end
    valid = 1'b0;
    check({tag, "_ready"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, result, exp);
    @(posedge g_clk); #1;
    check({tag, "_pulse"}, 32'(ready), 32'd0);
    check({tag, "_hold"}, result, exp);
    last_result = exp;
  endtask

  initial begin
    logic        seen;
    logic [31:0] a, b;
    logic [4:0]  p;
    logic        hi, cl;

    // Reset state
    repeat (2) @(posedge g_clk);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;

    // Directed cases
    run_op("w32_lo", 32'd5, 32'd7, 5'b00001, 1'b0, 1'b0, 32'h0000_0023);
    run_op("w32_hi", 32'd5, 32'd7, 5'b00001, 1'b1, 1'b0, 32'h0000_0000);
    run_op("w16_lo", 32'hFFFF_0003, 32'h0002_0004, 5'b00010, 1'b0, 1'b0, 32'hFFFE_000C);
    run_op("w16_hi", 32'hFFFF_0003, 32'h0002_0004, 5'b00010, 1'b1, 1'b0, 32'h0001_0000);
    run_op("w4_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b01000, 1'b0, 1'b0, 32'h1111_1111);
    run_op("w4_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b01000, 1'b1, 1'b0, 32'hEEEE_EEEE);
    run_op("w2_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 1'b0, 1'b0, 32'h5555_5555);
    run_op("w2_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 1'b1, 1'b0, 32'hAAAA_AAAA);
    run_op("w8_lo", 32'h1020_3040, 32'h0202_0202, 5'b00100, 1'b0, 1'b0, 32'h2040_6080);
    run_op("w32_max_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 1'b1, 1'b0, 32'hFFFF_FFFE);
    run_op("clmul", 32'd3, 32'd3, 5'b00001, 1'b0, 1'b1, CL_EN ? 32'd5 : 32'd9);
    run_op("pw_multi", 32'h1234_5678, 32'h9ABC_DEF0, 5'b00011, 1'b0, 1'b0, 32'h0);
    run_op("w16_nz", 32'h0003_0005, 32'h0007_0009, 5'b00010, 1'b0, 1'b0, 32'h0015_002D);
    run_op("pw_zero", 32'h1234_5678, 32'h9ABC_DEF0, 5'b00000, 1'b1, 1'b0, 32'h0);

    // Flush at BUSY cycle 5: no ready, result unchanged
    run_op("pre_flush", 32'h0000_1234, 32'h0000_0011, 5'b00001, 1'b0, 1'b0, 32'h0001_3574);
    @(negedge g_clk);
    lhs = 32'hDEAD_BEEF; rhs = 32'h0BAD_F00D; pw = 5'b00001; high = 1'b0; valid = 1'b1;
    repeat (6) @(posedge g_clk);
    #1;
    check("flush_busy_ready", 32'(ready), 32'd0);
    flush = 1'b1; valid = 1'b0;
    @(posedge g_clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge g_clk); #1;
      if (ready) seen = 1'b1;
    end
    check("flush_no_ready", 32'(seen), 32'd0);
    check("flush_result_hold", result, last_result);
    run_op("after_flush", 32'd11, 32'd13, 5'b00001, 1'b0, 1'b0, 32'd143);

    // Asynchronous reset mid-BUSY
    @(negedge g_clk);
    lhs = 32'hFFFF_FFFF; rhs = 32'hFFFF_FFFF; pw = 5'b00001; high = 1'b0; valid = 1'b1;
    repeat (10) @(posedge g_clk);
    #2;
    g_resetn = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_result", result, 32'd0);
    valid = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    repeat (3) @(posedge g_clk);
    #1;
    check("rst_release_ready", 32'(ready), 32'd0);
    check("rst_release_result", result, 32'd0);

    // Random operations against the model
    for (int t = 0; t < 40; t++) begin
      a  = $urandom;
      b  = $urandom;
      p  = (t % 8 == 7) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      hi = 1'($urandom);
      cl = 1'($urandom);
      run_op($sformatf("rand%0d", t), a, b, p, hi, cl, ref_mul(a, b, p, hi, cl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
